// File: rtl/imm_gen_pkg.sv
// Purpose: shared opcode constants and immediate-format codes for the immediate generator.
// Contents: RV base opcodes that carry an immediate, plus the imm_fmt encoding seen on the
//           imm_gen_pipe output port (0=NONE 1=I 2=S 3=B 4=U 5=J).
package imm_gen_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Purpose: combinational immediate decoder, instruction word -> sign-extended immediate + format.
// Ports:   instruction (in, 32) -> imm (XLEN), fmt (format code), illegal (opcode has no format).
// Latency: zero cycles, purely combinational; no handshake.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int BR_SCALED = 1
) (
   input  logic [31:0]     instruction,
   output logic [XLEN-1:0] imm,
   output imm_fmt_e        fmt,
   output logic            illegal
);

   // Everything is built at 64 bits and truncated, so the XLEN=32 case needs no
   // special handling (U-type then fills the word exactly with no extension).
   logic [63:0] imm64;
   logic        s;

   assign s = instruction[31];

   always_comb begin
      imm64   = '0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      case (instruction[6:0])
         OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: begin
            imm64 = {{52{s}}, instruction[31:20]};
            fmt   = FMT_I;
         end
         OP_STORE: begin
            imm64 = {{52{s}}, instruction[31:25], instruction[11:7]};
            fmt   = FMT_S;
         end
         OP_BRANCH: begin
            // Unscaled mode keeps the legacy half-word offset (no implicit bit 0).
            if (BR_SCALED != 0)
               imm64 = {{51{s}}, instruction[31], instruction[7], instruction[30:25],
                        instruction[11:8], 1'b0};
            else
               imm64 = {{52{s}}, instruction[31], instruction[7], instruction[30:25],
                        instruction[11:8]};
            fmt = FMT_B;
         end
         OP_LUI, OP_AUIPC: begin
            imm64 = {{32{s}}, instruction[31:12], 12'b0};
            fmt   = FMT_U;
         end
         OP_JAL: begin
            if (BR_SCALED != 0)
               imm64 = {{43{s}}, instruction[31], instruction[19:12], instruction[20],
                        instruction[30:21], 1'b0};
            else
               imm64 = {{44{s}}, instruction[31], instruction[19:12], instruction[20],
                        instruction[30:21]};
            fmt = FMT_J;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

   assign imm = imm64[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Purpose: pipelined immediate generator; decodes each accepted instruction into a DEPTH-entry FIFO.
// Ports:   in_valid/in_ready/instruction/in_tag on the input side, out_valid/out_ready/imm_data/
//          imm_fmt/imm_illegal/out_tag on the output side, plus clk, synchronous reset and flush.
// Latency: one cycle from accept to head; in_ready is purely registered (no out_ready->in_ready path).
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int DEPTH     = 2,
   parameter int TAG_W     = 8,
   parameter int BR_SCALED = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_data,
   output logic [2:0]       imm_fmt,
   output logic             imm_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [XLEN-1:0]  dec_imm;
   imm_fmt_e         dec_fmt;
   logic             dec_illegal;

   logic [XLEN-1:0]  mem_imm [DEPTH];
   logic [2:0]       mem_fmt [DEPTH];
   logic             mem_ill [DEPTH];
   logic [TAG_W-1:0] mem_tag [DEPTH];

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push;
   logic             pop;

   imm_decode #(
      .XLEN      (XLEN),
      .BR_SCALED (BR_SCALED)
   ) u_decode (
      .instruction (instruction),
      .imm         (dec_imm),
      .fmt         (dec_fmt),
      .illegal     (dec_illegal)
   );

   // Explicit wrap so non-power-of-two depths cycle correctly.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign in_ready  = (count != FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset: it is only observed through the out_valid gate below.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_imm[wr_ptr] <= dec_imm;
         mem_fmt[wr_ptr] <= dec_fmt;
         mem_ill[wr_ptr] <= dec_illegal;
         mem_tag[wr_ptr] <= in_tag;
      end
   end

   assign imm_data    = out_valid ? mem_imm[rd_ptr] : '0;
   assign imm_fmt     = out_valid ? mem_fmt[rd_ptr] : 3'd0;
   assign imm_illegal = out_valid ? mem_ill[rd_ptr] : 1'b0;
   assign out_tag     = out_valid ? mem_tag[rd_ptr] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Purpose: directed and random-handshake bench for imm_gen_pipe (XLEN=64, DEPTH=2, BR_SCALED=1).
// Ports:   none; drives the DUT after each rising edge and samples 1 time unit later.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [7:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] imm_data;
   logic [2:0]  imm_fmt;
   logic        imm_illegal;
   logic [7:0]  out_tag;

   int errors = 0;
   int checks = 0;

   localparam int NV = 11;
   // Hand-decoded vectors: instruction, immediate, format, illegal.
   logic [31:0] t_inst [NV] = '{32'hFF813083, 32'h00B13423, 32'hFE000EE3, 32'h800000B7,
                                32'h0080006F, 32'hFFFFFFFF, 32'h7FF00093, 32'h00001017,
                                32'h00008067, 32'h00000033, 32'h0010809B};
   logic [63:0] t_imm  [NV] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'd8, 64'hFFFF_FFFF_FFFF_FFFC,
                                64'hFFFF_FFFF_8000_0000, 64'd8, 64'd0, 64'h7FF, 64'h1000,
                                64'd0, 64'd0, 64'd1};
   logic [2:0]  t_fmt  [NV] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd4, 3'd1, 3'd0, 3'd1};
   logic        t_ill  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   imm_gen_pipe #(
      .XLEN      (64),
      .DEPTH     (2),
      .TAG_W     (8),
      .BR_SCALED (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .imm_data    (imm_data),
      .imm_fmt     (imm_fmt),
      .imm_illegal (imm_illegal),
      .out_tag     (out_tag)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instruction = '0; in_tag = '0;
      tick; tick;
      reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (imm_data !== 64'd0) begin errors++; $display("FAIL reset_imm got=%h exp=0", imm_data); end
      checks++; if (imm_fmt !== 3'd0 || imm_illegal !== 1'b0 || out_tag !== 8'd0) begin
         errors++; $display("FAIL reset_fields fmt=%0d ill=%b tag=%h exp 0/0/0", imm_fmt, imm_illegal, out_tag);
      end
   endtask

   task automatic test_load_latency;
      tick;
      out_ready = 1'b0; in_valid = 1'b1; instruction = 32'hFF813083; in_tag = 8'hA1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ld_no_comb_path out_valid=%b exp=0", out_valid); end
      tick;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ld_latency out_valid=%b exp=1", out_valid); end
      checks++; if (imm_data !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL ld_imm got=%h exp=fffffffffffffff8", imm_data); end
      checks++; if (imm_fmt !== 3'd1 || out_tag !== 8'hA1) begin
         errors++; $display("FAIL ld_fmt_tag fmt=%0d tag=%h exp 1/a1", imm_fmt, out_tag);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ld_pop out_valid=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1; in_valid = 1'b1; instruction = 32'h00B13423; in_tag = 8'h01;
      tick;
      instruction = 32'hFE000EE3; in_tag = 8'h02;
      checks++; if (out_valid !== 1'b1 || imm_data !== 64'd8 || imm_fmt !== 3'd2 || out_tag !== 8'h01) begin
         errors++; $display("FAIL b2b_sd v=%b imm=%h fmt=%0d tag=%h exp 1/8/2/01", out_valid, imm_data, imm_fmt, out_tag);
      end
      tick;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || imm_data !== 64'hFFFF_FFFF_FFFF_FFFC || imm_fmt !== 3'd3 || out_tag !== 8'h02) begin
         errors++; $display("FAIL b2b_beq v=%b imm=%h fmt=%0d tag=%h exp 1/fffffffffffffffc/3/02", out_valid, imm_data, imm_fmt, out_tag);
      end
      tick;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain out_valid=%b exp=0", out_valid); end
   endtask

   task automatic test_decode_table;
      for (int k = 0; k < NV; k++) begin
         out_ready = 1'b0; in_valid = 1'b1; instruction = t_inst[k]; in_tag = 8'(k + 16);
         tick;
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || imm_data !== t_imm[k] || imm_fmt !== t_fmt[k] ||
             imm_illegal !== t_ill[k] || out_tag !== 8'(k + 16)) begin
            errors++;
            $display("FAIL decode_%0d inst=%h v=%b imm=%h fmt=%0d ill=%b tag=%h exp imm=%h fmt=%0d ill=%b tag=%h",
                     k, t_inst[k], out_valid, imm_data, imm_fmt, imm_illegal, out_tag,
                     t_imm[k], t_fmt[k], t_ill[k], 8'(k + 16));
         end
         out_ready = 1'b1;
         tick;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_full;
      logic [7:0] got[$];
      logic       acc;
      int         cyc;
      out_ready = 1'b0; in_valid = 1'b1; instruction = t_inst[0]; in_tag = 8'd1;
      tick;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_one in_ready=%b exp=1", in_ready); end
      in_tag = 8'd2;
      tick;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_two in_ready=%b exp=0", in_ready); end
      in_tag = 8'd3;
      tick;
      checks++; if (in_ready !== 1'b0 || out_tag !== 8'd1) begin
         errors++; $display("FAIL full_hold in_ready=%b head=%h exp 0/01", in_ready, out_tag);
      end
      cyc = 0;
      while (got.size() < 3 && cyc < 10) begin
         out_ready = 1'b1;
         if (out_valid) got.push_back(out_tag);
         acc = in_valid && in_ready;
         tick;
         if (acc) in_valid = 1'b0;
         cyc++;
      end
      out_ready = 1'b0; in_valid = 1'b0;
      checks++;
      if (got.size() != 3) begin
         errors++; $display("FAIL full_drain_count got=%0d exp=3", got.size());
      end else if (got[0] !== 8'd1 || got[1] !== 8'd2 || got[2] !== 8'd3) begin
         errors++; $display("FAIL full_drain_order got=%h,%h,%h exp=01,02,03", got[0], got[1], got[2]);
      end
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_empty out_valid=%b exp=0", out_valid); end
   endtask

   task automatic test_flush;
      out_ready = 1'b0; in_valid = 1'b1; instruction = t_inst[1]; in_tag = 8'h31;
      tick;
      in_tag = 8'h32;
      tick;
      in_tag = 8'h55; instruction = t_inst[3]; flush = 1'b1; out_ready = 1'b1;
      tick;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_empty v=%b rdy=%b exp 0/1", out_valid, in_ready);
      end
      checks++; if (imm_data !== 64'd0 || out_tag !== 8'd0) begin
         errors++; $display("FAIL flush_zero imm=%h tag=%h exp 0/00", imm_data, out_tag);
      end
      tick; tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost out_valid=%b exp=0", out_valid); end
   endtask

   task automatic test_random(input int n);
      int   q[$];
      int   sent = 0;
      int   recv = 0;
      int   cyc  = 0;
      int   h;
      logic pv = 1'b0;
      logic push, pop;
      while (recv < n && cyc < n * 8) begin
         checks++;
         if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
            errors++; $display("FAIL rnd_flags cyc=%0d v=%b rdy=%b model_cnt=%0d", cyc, out_valid, in_ready, q.size());
         end
         if (q.size() != 0 && out_valid) begin
            h = q[0];
            checks++;
            if (imm_data !== t_imm[h % NV] || imm_fmt !== t_fmt[h % NV] ||
                imm_illegal !== t_ill[h % NV] || out_tag !== h[7:0]) begin
               errors++;
               $display("FAIL rnd_head seq=%0d imm=%h fmt=%0d ill=%b tag=%h exp imm=%h fmt=%0d ill=%b tag=%h",
                        h, imm_data, imm_fmt, imm_illegal, out_tag, t_imm[h % NV], t_fmt[h % NV], t_ill[h % NV], h[7:0]);
            end
         end
         if (!pv && sent < n) pv = ($urandom_range(0, 3) != 0);
         in_valid    = pv;
         instruction = t_inst[sent % NV];
         in_tag      = sent[7:0];
         out_ready   = ($urandom_range(0, 2) != 0);
         push = pv && (q.size() < 2);
         pop  = (q.size() != 0) && out_ready;
         tick;
         if (pop) begin void'(q.pop_front()); recv++; end
         if (push) begin q.push_back(sent); sent++; pv = 1'b0; end
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (recv != n) begin errors++; $display("FAIL rnd_total recv=%0d exp=%0d", recv, n); end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0; in_valid = 1'b1; instruction = t_inst[4]; in_tag = 8'h71;
      tick;
      in_tag = 8'h72;
      reset = 1'b1;
      tick;
      reset = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm_data !== 64'd0) begin
         errors++; $display("FAIL rst_mid v=%b rdy=%b imm=%h exp 0/1/0", out_valid, in_ready, imm_data);
      end
      out_ready = 1'b1;
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_after out_valid=%b exp=0", out_valid); end
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset;
      test_load_latency;
      test_back_to_back;
      test_decode_table;
      test_full;
      test_flush;
      test_random(1500);
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
